// File: rtl/alu_uart_interface.sv
// Sequencer between UART RX/TX and a combinational ALU: collects A, B, op bytes,
// launches one TX of the ALU result, then waits for TX completion.
module alu_uart_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    S_DATA_A  = 3'd0,
    S_DATA_B  = 3'd1,
    S_OP      = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

  state_t state;

  // o_busy is registered alongside the state so it always equals the
  // decode (state == S_SEND || state == S_WAIT_TX).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_DATA_A;
      o_data_a    <= '0;
      o_data_b    <= '0;
      o_operation <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        S_DATA_A: if (i_rx_done) begin
          o_data_a <= i_rx_data;
          state    <= S_DATA_B;
        end
        S_DATA_B: if (i_rx_done) begin
          o_data_b <= i_rx_data;
          state    <= S_OP;
        end
        S_OP: if (i_rx_done) begin
          o_operation <= i_rx_data[NB_OP-1:0];
          o_busy      <= 1'b1;
          state       <= S_SEND;
        end
        S_SEND: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= S_WAIT_TX;
        end
        S_WAIT_TX: if (i_tx_done) begin
          // any coincident rx byte is dropped, not taken as operand A
          o_busy <= 1'b0;
          state  <= S_DATA_A;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_DATA_A;
        end
      endcase
    end
  end

endmodule
